// File: rtl/microstate_sequencer.sv
// microstate_sequencer: control-unit next-state logic.
// Holds the current microstate and selects the next one from NS_SEL each cycle.
// Optional feature macro: MICROSEQ_TIMEOUT_EN (WAIT_MOC timeout abort to ABORT_STATE).
module microstate_sequencer #(
  parameter int unsigned     SW          = 8,
  parameter logic [SW-1:0]   RESET_STATE = '0,
  parameter logic [SW-1:0]   FETCH_STATE = SW'(1),
  parameter logic [SW-1:0]   ABORT_STATE = SW'(60),
  parameter int unsigned     TIMEOUT     = 15
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [SW-1:0] ENC_IN,
  input  logic [SW-1:0] CR_ADDR,
  input  logic [2:0]    NS_SEL,
  input  logic          COND,
  input  logic          MOC,
  output logic [SW-1:0] STATE,
  output logic          STALL,
  output logic          ERR
);

  typedef enum logic [2:0] {
    NS_FETCH    = 3'd0,
    NS_INCR     = 3'd1,
    NS_DECODE   = 3'd2,
    NS_JUMP     = 3'd3,
    NS_CJUMP    = 3'd4,
    NS_WAIT_MOC = 3'd5,
    NS_CALL     = 3'd6,
    NS_RETURN   = 3'd7
  } ns_mode_t;

  ns_mode_t      mode;
  logic [SW-1:0] link;
  logic [SW-1:0] state_inc;
  logic          at_max;
  logic [SW-1:0] next_state;
  logic [SW-1:0] next_link;
  logic          next_err;

  assign mode      = ns_mode_t'(NS_SEL);
  assign state_inc = STATE + 1'b1;
  assign at_max    = &STATE;

`ifdef MICROSEQ_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] next_wait_cnt;
  logic          expired;

  assign expired = (wait_cnt == CW'(TIMEOUT - 1));

  // Stalled-cycle counter: counts only while waiting without MOC; clears on exit or abort.
  always_comb begin
    next_wait_cnt = '0;
    if (mode == NS_WAIT_MOC && !MOC && !expired)
      next_wait_cnt = wait_cnt + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) wait_cnt <= '0;
    else       wait_cnt <= next_wait_cnt;
  end
`else
  // Timeout configuration is inert in this build.
  logic unused_cfg;
  assign unused_cfg = (^ABORT_STATE) ^ TIMEOUT[0];
`endif

  // State, link and error-pulse registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STATE <= RESET_STATE;
      link  <= RESET_STATE;
      ERR   <= 1'b0;
    end else begin
      STATE <= next_state;
      link  <= next_link;
      ERR   <= next_err;
    end
  end

  // Next-state selection by NS_SEL mode.
  always_comb begin
    next_state = STATE;
    next_link  = link;
    next_err   = 1'b0;
    case (mode)
      NS_FETCH:  next_state = FETCH_STATE;
      NS_INCR: begin
        next_state = at_max ? RESET_STATE : state_inc;
        next_err   = at_max;
      end
      NS_DECODE: next_state = (ENC_IN == '0) ? FETCH_STATE : ENC_IN;
      NS_JUMP:   next_state = CR_ADDR;
      NS_CJUMP: begin
        if (COND) begin
          next_state = CR_ADDR;
        end else begin
          next_state = at_max ? RESET_STATE : state_inc;
          next_err   = at_max;
        end
      end
      NS_WAIT_MOC: begin
        // MOC takes priority over a simultaneous timeout expiry.
        if (MOC) begin
          next_state = state_inc;
        end
`ifdef MICROSEQ_TIMEOUT_EN
        else if (expired) begin
          next_state = ABORT_STATE;
          next_err   = 1'b1;
        end
`endif
      end
      NS_CALL: begin
        next_link  = state_inc;
        next_state = CR_ADDR;
      end
      NS_RETURN: next_state = link;
      default:   next_state = STATE;
    endcase
  end

  // Stall indication: waiting on memory that has not completed.
  always_comb begin
    STALL = (mode == NS_WAIT_MOC) && !MOC;
  end

endmodule

// File: tb/tb_microstate_sequencer.sv
// Self-checking bench for microstate_sequencer using a reference model and an
// expected-result queue. Honors MICROSEQ_TIMEOUT_EN for the timeout behaviour.
module tb_microstate_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] ENC_IN;
  logic [7:0] CR_ADDR;
  logic [2:0] NS_SEL;
  logic       COND;
  logic       MOC;
  logic [7:0] STATE;
  logic       STALL;
  logic       ERR;

  microstate_sequencer #(
    .SW          (8),
    .RESET_STATE (8'd0),
    .FETCH_STATE (8'd1),
    .ABORT_STATE (8'd60),
    .TIMEOUT     (15)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENC_IN  (ENC_IN),
    .CR_ADDR (CR_ADDR),
    .NS_SEL  (NS_SEL),
    .COND    (COND),
    .MOC     (MOC),
    .STATE   (STATE),
    .STALL   (STALL),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  localparam logic [2:0] FETCH = 3'd0, INCR = 3'd1, DECODE = 3'd2, JUMP = 3'd3,
                         CJUMP = 3'd4, WAITM = 3'd5, CALL = 3'd6, RET = 3'd7;

  typedef struct {
    logic [7:0] st;
    logic       err;
  } exp_t;

  exp_t sbq[$];

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state.
  logic [7:0] m_state;
  logic [7:0] m_link;
  int unsigned m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 8'd0;
    m_link  = 8'd0;
    m_cnt   = 0;
  endtask

  // Drive one microinstruction, predict its result, then compare after the edge.
  task automatic step(input logic [2:0] ns, input logic [7:0] enc, input logic [7:0] cr,
                      input logic cond, input logic moc);
    exp_t e;
    logic [7:0] nxt;
    logic err;
    @(negedge CLK);
    NS_SEL  = ns;
    ENC_IN  = enc;
    CR_ADDR = cr;
    COND    = cond;
    MOC     = moc;
    #1;
    check_eq("stall", {31'd0, STALL}, {31'd0, (ns == WAITM) && !moc});
    err = 1'b0;
    nxt = m_state;
    case (ns)
      FETCH:  nxt = 8'd1;
      INCR:   begin nxt = m_state + 8'd1; err = (m_state == 8'hFF); end
      DECODE: nxt = (enc == 8'd0) ? 8'd1 : enc;
      JUMP:   nxt = cr;
      CJUMP:  if (cond) nxt = cr;
              else begin nxt = m_state + 8'd1; err = (m_state == 8'hFF); end
      WAITM: begin
        if (moc) begin
          nxt = m_state + 8'd1;
          m_cnt = 0;
        end else begin
`ifdef MICROSEQ_TIMEOUT_EN
          if (m_cnt == 14) begin
            nxt = 8'd60;
            err = 1'b1;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
`endif
        end
      end
      CALL:   begin m_link = m_state + 8'd1; nxt = cr; end
      default: nxt = m_link;
    endcase
    if (ns != WAITM) m_cnt = 0;
    m_state = nxt;
    e.st  = nxt;
    e.err = err;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    check_eq("state", {24'd0, STATE}, {24'd0, e.st});
    check_eq("err", {31'd0, ERR}, {31'd0, e.err});
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear immediately.
  task automatic do_reset();
    #2;
    RESET = 1'b1;
    #1;
    check_eq("rst_state", {24'd0, STATE}, 32'd0);
    check_eq("rst_err", {31'd0, ERR}, 32'd0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; ENC_IN = '0; CR_ADDR = '0; NS_SEL = FETCH; COND = 1'b0; MOC = 1'b0;
    model_reset();
    #12;
    check_eq("init_state", {24'd0, STATE}, 32'd0);
    check_eq("init_err", {31'd0, ERR}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // RETURN with no prior CALL goes to the reset state.
    step(JUMP, 8'd0, 8'd5, 1'b0, 1'b0);
    step(RET, 8'd0, 8'd77, 1'b1, 1'b0);

    // Reset mid-operation.
    step(JUMP, 8'd0, 8'd23, 1'b0, 1'b0);
    do_reset();
    step(FETCH, 8'd9, 8'd9, 1'b1, 1'b1);

    // Reset while ERR pulse is high.
    step(JUMP, 8'd0, 8'hFF, 1'b0, 1'b0);
    step(INCR, 8'd0, 8'd0, 1'b0, 1'b0);
    do_reset();

    // Decode dispatch, including null instruction.
    step(FETCH, 8'd0, 8'd0, 1'b0, 1'b0);
    step(DECODE, 8'd17, 8'd99, 1'b1, 1'b0);
    step(FETCH, 8'd0, 8'd0, 1'b0, 1'b0);
    step(DECODE, 8'd0, 8'd99, 1'b1, 1'b0);

    // Conditional jump and wrap.
    step(JUMP, 8'd0, 8'd30, 1'b0, 1'b0);
    step(CJUMP, 8'd0, 8'd44, 1'b1, 1'b0);
    step(JUMP, 8'd0, 8'd30, 1'b0, 1'b0);
    step(CJUMP, 8'd0, 8'd44, 1'b0, 1'b0);
    step(JUMP, 8'd0, 8'hFF, 1'b0, 1'b0);
    step(INCR, 8'd0, 8'd0, 1'b0, 1'b0);
    step(INCR, 8'd0, 8'd0, 1'b0, 1'b0);
    step(JUMP, 8'd0, 8'hFF, 1'b0, 1'b0);
    step(CJUMP, 8'd0, 8'd44, 1'b0, 1'b0);

    // Call / return, repeated return, nested call.
    step(JUMP, 8'd0, 8'd10, 1'b0, 1'b0);
    step(CALL, 8'd0, 8'd50, 1'b0, 1'b0);
    step(RET, 8'd0, 8'd0, 1'b0, 1'b0);
    step(RET, 8'd0, 8'd0, 1'b0, 1'b0);
    step(JUMP, 8'd0, 8'd20, 1'b0, 1'b0);
    step(CALL, 8'd0, 8'd70, 1'b0, 1'b0);
    step(CALL, 8'd0, 8'd90, 1'b0, 1'b0);
    step(RET, 8'd0, 8'd0, 1'b0, 1'b0);

    // Wait on memory.
    step(JUMP, 8'd0, 8'd12, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(WAITM, 8'd0, 8'd33, 1'b1, 1'b0);
    step(WAITM, 8'd0, 8'd33, 1'b1, 1'b1);

    // Reset mid-wait must clear the stall counter.
    step(JUMP, 8'd0, 8'd12, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(WAITM, 8'd0, 8'd0, 1'b0, 1'b0);
    do_reset();
    step(JUMP, 8'd0, 8'd12, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(WAITM, 8'd0, 8'd0, 1'b0, 1'b0);
    step(WAITM, 8'd0, 8'd0, 1'b0, 1'b1);

    // Leaving WAIT_MOC clears the counter.
    step(JUMP, 8'd0, 8'd12, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(WAITM, 8'd0, 8'd0, 1'b0, 1'b0);
    step(JUMP, 8'd0, 8'd12, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(WAITM, 8'd0, 8'd0, 1'b0, 1'b0);

    // Long stall: abort at the 15th cycle when enabled, otherwise hold.
    step(JUMP, 8'd0, 8'd12, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(WAITM, 8'd0, 8'd0, 1'b0, 1'b0);

    // MOC on the 15th stalled cycle wins over timeout.
    step(JUMP, 8'd0, 8'd12, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(WAITM, 8'd0, 8'd0, 1'b0, 1'b0);
    step(WAITM, 8'd0, 8'd0, 1'b0, 1'b1);

    // Random mix of all modes.
    for (int i = 0; i < 300; i++)
      step(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
